// File: rtl/placement_pkg.sv
// Shared types for the placement read-back path: record status codes,
// the empty-slot sentinel and the reader state encoding.
package placement_pkg;

   typedef enum logic [1:0] {
      ST_OK       = 2'd0,
      ST_UNPLACED = 2'd1,
      ST_OOR      = 2'd2,
      ST_MISMATCH = 2'd3
   } status_e;

   localparam int EMPTY = -1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_POS,
      S_W_POS,
      S_CHK_POS,
      S_W_GRID,
      S_CHK_GRID,
      S_EMIT,
      S_NEXT,
      S_DONE
   } rd_state_e;

endpackage

// File: rtl/placement_reader_bbox.sv
// Min/max tracker over accepted OK records; only present when
// PLACEMENT_READER_BBOX_EN is defined.
`ifdef PLACEMENT_READER_BBOX_EN
module placement_reader_bbox
   import placement_pkg::*;
#(
   parameter int GRID_N = 4,
   parameter int DW     = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          update,
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] y,
   output logic [DW-1:0] xmin,
   output logic [DW-1:0] xmax,
   output logic [DW-1:0] ymin,
   output logic [DW-1:0] ymax
);

   // min starts above max so a run with no OK record reads as an empty box
   localparam logic signed [DW-1:0] MIN_INIT = DW'(GRID_N - 1);

   logic signed [DW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
   logic signed [DW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;

   always_comb begin
      xmin_d = xmin_q;
      xmax_d = xmax_q;
      ymin_d = ymin_q;
      ymax_d = ymax_q;
      if (clear) begin
         xmin_d = MIN_INIT;
         xmax_d = '0;
         ymin_d = MIN_INIT;
         ymax_d = '0;
      end else if (update) begin
         if ($signed(x) < xmin_q) xmin_d = $signed(x);
         if ($signed(x) > xmax_q) xmax_d = $signed(x);
         if ($signed(y) < ymin_q) ymin_d = $signed(y);
         if ($signed(y) > ymax_q) ymax_d = $signed(y);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         xmin_q <= MIN_INIT;
         xmax_q <= '0;
         ymin_q <= MIN_INIT;
         ymax_q <= '0;
      end else begin
         xmin_q <= xmin_d;
         xmax_q <= xmax_d;
         ymin_q <= ymin_d;
         ymax_q <= ymax_d;
      end
   end

   assign xmin = xmin_q;
   assign xmax = xmax_q;
   assign ymin = ymin_q;
   assign ymax = ymax_q;

endmodule
`endif

// File: rtl/placement_reader.sv
// Placement read-back engine: walks node ids, reads (x,y), cross-checks the grid
// cell and streams one status record per node. Bbox tracking: PLACEMENT_READER_BBOX_EN.
module placement_reader
   import placement_pkg::*;
#(
   parameter int NODES    = 16,
   parameter int GRID_N   = 4,
   parameter int DW       = 32,
   parameter int READ_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          rePX,
   output logic          rePY,
   output logic [DW-1:0] addrPX,
   output logic [DW-1:0] addrPY,
   input  logic [DW-1:0] doutPX,
   input  logic [DW-1:0] doutPY,
   output logic          reGrid,
   output logic [DW-1:0] addrGrid,
   input  logic [DW-1:0] doutGrid,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [DW-1:0] o_node,
   output logic [DW-1:0] o_x,
   output logic [DW-1:0] o_y,
   output logic [1:0]    o_status,
   output logic [DW-1:0] ok_count,
   output logic [DW-1:0] err_count,
   output logic [DW-1:0] bbox_xmin,
   output logic [DW-1:0] bbox_xmax,
   output logic [DW-1:0] bbox_ymin,
   output logic [DW-1:0] bbox_ymax
);

   localparam logic [DW-1:0]        LAST_NODE = DW'(NODES - 1);
   localparam logic [DW-1:0]        GRID_W    = DW'(GRID_N);
   localparam logic signed [DW-1:0] GRID_MAX  = DW'(GRID_N - 1);
   localparam logic [DW-1:0]        EMPTY_W   = DW'(EMPTY);
   localparam bit                   HAS_WAIT  = (READ_LAT > 1);
   localparam logic [7:0]           WAIT_LAST = HAS_WAIT ? 8'(READ_LAT - 2) : 8'd0;

   rd_state_e     state_q, state_d;
   status_e       status_q, status_d;
   logic [DW-1:0] node_q, node_d, x_q, x_d, y_q, y_d;
   logic [DW-1:0] ok_q, ok_d, err_q, err_d;
   logic [7:0]    wait_q, wait_d;

   logic          busy_q, busy_d, done_q, done_d, valid_q, valid_d;
   logic          re_pos_q, re_pos_d, re_grid_q, re_grid_d;
   logic [DW-1:0] addr_pos_q, addr_pos_d, addr_grid_q, addr_grid_d;

   logic          pos_empty, pos_in_range;
   logic [DW-1:0] grid_addr;

   assign pos_empty    = (doutPX == EMPTY_W) || (doutPY == EMPTY_W);
   assign pos_in_range = !doutPX[DW-1] && !doutPY[DW-1] &&
                         ($signed(doutPX) <= GRID_MAX) && ($signed(doutPY) <= GRID_MAX);
   // Both coordinates are known non-negative here, so an unsigned product is exact.
   assign grid_addr    = doutPX * GRID_W + doutPY;

   // Next-state and datapath
   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      node_d   = node_q;
      x_d      = x_q;
      y_d      = y_q;
      ok_d     = ok_q;
      err_d    = err_q;
      wait_d   = wait_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               node_d  = '0;
               ok_d    = '0;
               err_d   = '0;
               state_d = S_RD_POS;
            end
         end
         S_RD_POS: begin
            wait_d  = '0;
            state_d = HAS_WAIT ? S_W_POS : S_CHK_POS;
         end
         S_W_POS: begin
            if (wait_q == WAIT_LAST) state_d = S_CHK_POS;
            else                     wait_d  = wait_q + 8'd1;
         end
         S_CHK_POS: begin
            x_d    = doutPX;
            y_d    = doutPY;
            wait_d = '0;
            if (pos_empty) begin
               status_d = ST_UNPLACED;
               state_d  = S_EMIT;
            end else if (!pos_in_range) begin
               status_d = ST_OOR;
               state_d  = S_EMIT;
            end else begin
               state_d = HAS_WAIT ? S_W_GRID : S_CHK_GRID;
            end
         end
         S_W_GRID: begin
            if (wait_q == WAIT_LAST) state_d = S_CHK_GRID;
            else                     wait_d  = wait_q + 8'd1;
         end
         S_CHK_GRID: begin
            status_d = (doutGrid == node_q) ? ST_OK : ST_MISMATCH;
            state_d  = S_EMIT;
         end
         S_EMIT: begin
            if (o_ready) begin
               if (status_q == ST_OK) ok_d  = ok_q + DW'(1);
               else                   err_d = err_q + DW'(1);
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (node_q == LAST_NODE) begin
               state_d = S_DONE;
            end else begin
               node_d  = node_q + DW'(1);
               state_d = S_RD_POS;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: status flags track the upcoming state; read strobes are loaded by
   // the issuing state, so READ_LAT counts from that state to the sampling state.
   always_comb begin
      busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d      = (state_d == S_DONE);
      valid_d     = (state_d == S_EMIT);
      re_pos_d    = (state_q == S_RD_POS);
      addr_pos_d  = re_pos_d ? node_q : addr_pos_q;
      re_grid_d   = (state_q == S_CHK_POS) &&
                    ((state_d == S_W_GRID) || (state_d == S_CHK_GRID));
      addr_grid_d = re_grid_d ? grid_addr : addr_grid_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         status_q    <= ST_OK;
         node_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         ok_q        <= '0;
         err_q       <= '0;
         wait_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
         re_pos_q    <= 1'b0;
         re_grid_q   <= 1'b0;
         addr_pos_q  <= '0;
         addr_grid_q <= '0;
      end else begin
         state_q     <= state_d;
         status_q    <= status_d;
         node_q      <= node_d;
         x_q         <= x_d;
         y_q         <= y_d;
         ok_q        <= ok_d;
         err_q       <= err_d;
         wait_q      <= wait_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         valid_q     <= valid_d;
         re_pos_q    <= re_pos_d;
         re_grid_q   <= re_grid_d;
         addr_pos_q  <= addr_pos_d;
         addr_grid_q <= addr_grid_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rePX      = re_pos_q;
   assign rePY      = re_pos_q;
   assign addrPX    = addr_pos_q;
   assign addrPY    = addr_pos_q;
   assign reGrid    = re_grid_q;
   assign addrGrid  = addr_grid_q;
   assign o_valid   = valid_q;
   assign o_node    = node_q;
   assign o_x       = x_q;
   assign o_y       = y_q;
   assign o_status  = status_q;
   assign ok_count  = ok_q;
   assign err_count = err_q;

`ifdef PLACEMENT_READER_BBOX_EN
   logic bbox_clear, bbox_update;

   assign bbox_clear  = (state_q == S_IDLE) && start;
   assign bbox_update = (state_q == S_EMIT) && o_ready && (status_q == ST_OK);

   placement_reader_bbox #(
      .GRID_N (GRID_N),
      .DW     (DW)
   ) u_bbox (
      .clk    (clk),
      .reset  (reset),
      .clear  (bbox_clear),
      .update (bbox_update),
      .x      (x_q),
      .y      (y_q),
      .xmin   (bbox_xmin),
      .xmax   (bbox_xmax),
      .ymin   (bbox_ymin),
      .ymax   (bbox_ymax)
   );
`else
   assign bbox_xmin = '0;
   assign bbox_xmax = '0;
   assign bbox_ymin = '0;
   assign bbox_ymax = '0;
`endif

endmodule

// File: tb/tb_placement_reader.sv
// Directed bench for placement_reader (NODES=4, GRID_N=4, READ_LAT=2) with
// behavioural position/grid RAMs and hand-computed expected records.
module tb_placement_reader;

   localparam int NODES  = 4;
   localparam int GRID_N = 4;
   localparam int DW     = 32;
   localparam int BUDGET = 300;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, rePX, rePY, reGrid, o_valid;
   logic          o_ready = 1'b0;
   logic [DW-1:0] addrPX, addrPY, addrGrid;
   logic [DW-1:0] doutPX = '0, doutPY = '0, doutGrid = '0;
   logic [DW-1:0] o_node, o_x, o_y, ok_count, err_count;
   logic [DW-1:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
   logic [1:0]    o_status;

   placement_reader #(
      .NODES    (NODES),
      .GRID_N   (GRID_N),
      .DW       (DW),
      .READ_LAT (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .rePX      (rePX),
      .rePY      (rePY),
      .addrPX    (addrPX),
      .addrPY    (addrPY),
      .doutPX    (doutPX),
      .doutPY    (doutPY),
      .reGrid    (reGrid),
      .addrGrid  (addrGrid),
      .doutGrid  (doutGrid),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_node    (o_node),
      .o_x       (o_x),
      .o_y       (o_y),
      .o_status  (o_status),
      .ok_count  (ok_count),
      .err_count (err_count),
      .bbox_xmin (bbox_xmin),
      .bbox_xmax (bbox_xmax),
      .bbox_ymin (bbox_ymin),
      .bbox_ymax (bbox_ymax)
   );

   always #5 clk = ~clk;

   // RAMs: data for a strobe seen at one edge is present after that edge, so the
   // reader samples it READ_LAT=2 states after the issuing state.
   logic [DW-1:0] pos_x [NODES];
   logic [DW-1:0] pos_y [NODES];
   logic [DW-1:0] grid  [GRID_N*GRID_N];

   always @(posedge clk) begin
      if (rePX)   doutPX   <= pos_x[addrPX[1:0]];
      if (rePY)   doutPY   <= pos_y[addrPY[1:0]];
      if (reGrid) doutGrid <= grid[addrGrid[3:0]];
   end

   typedef struct {
      logic [DW-1:0] node;
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      logic [1:0]    st;
   } rec_t;

   rec_t          rec_q[$];
   logic [DW-1:0] grid_q[$];
   int            hs_q[$];
   int            done_cnt;
   int            n_checks = 0;
   int            n_bad = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] outs();
      return {busy, done, rePX, rePY, reGrid, o_valid, addrPX, addrPY, addrGrid,
              o_node, o_x, o_y, o_status, ok_count, err_count};
   endfunction

   // Scenario A: every node placed and consistent with the grid.
   task automatic load_a();
      for (int i = 0; i < GRID_N*GRID_N; i++) grid[i] = '1;
      pos_x[0] = 0; pos_y[0] = 0; grid[0]  = 0;
      pos_x[1] = 0; pos_y[1] = 1; grid[1]  = 1;
      pos_x[2] = 3; pos_y[2] = 3; grid[15] = 2;
      pos_x[3] = 2; pos_y[3] = 1; grid[9]  = 3;
   endtask

   task automatic run_scan(input int stall_cycles, input bit idle_ready,
                           input int extra_start_at, input int abort_at_grid,
                           output bit aborted);
      int hold;
      bit seen_done;
      rec_q.delete();
      grid_q.delete();
      hs_q.delete();
      done_cnt  = 0;
      hold      = 0;
      seen_done = 1'b0;
      aborted   = 1'b0;
      @(negedge clk);
      start   = 1'b1;
      o_ready = idle_ready;
      for (int cyc = 0; cyc < BUDGET && !seen_done; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            start = 1'b0;
            check("busy_after_start", busy, 1'b1);
         end
         if (cyc == extra_start_at) start = 1'b1;
         else if (extra_start_at >= 0 && cyc == extra_start_at + 1) start = 1'b0;
         if (reGrid) begin
            grid_q.push_back(addrGrid);
            if (grid_q.size() == abort_at_grid) begin
               reset   = 1'b0;
               aborted = 1'b1;
               return;
            end
         end
         if (done) begin
            done_cnt++;
            seen_done = 1'b1;
         end
         if (o_valid) begin
            if (o_node == 1 && hold < stall_cycles) begin
               check($sformatf("stall_hold%0d", hold), {o_valid, o_node, o_x, o_y, o_status},
                     {1'b1, 32'd1, pos_x[1], pos_y[1], 2'd0});
               o_ready = 1'b0;
               hold++;
            end else begin
               o_ready = 1'b1;
               rec_q.push_back('{o_node, o_x, o_y, o_status});
               hs_q.push_back(cyc);
            end
         end else begin
            o_ready = idle_ready;
         end
      end
      if (!seen_done) begin
         check("done_timeout", 1'b0, 1'b1);
      end else begin
         repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
         end
      end
   endtask

   task automatic verify(input string tag, input logic [7:0] exp_st, input int exp_ok,
                         input int exp_err, input int exp_greads);
      check({tag, "_nrec"}, rec_q.size(), NODES);
      for (int i = 0; i < NODES; i++) begin
         if (i < rec_q.size()) begin
            check($sformatf("%s_n%0d_id", tag, i), rec_q[i].node, i);
            check($sformatf("%s_n%0d_xy", tag, i), {rec_q[i].x, rec_q[i].y}, {pos_x[i], pos_y[i]});
            check($sformatf("%s_n%0d_st", tag, i), rec_q[i].st, exp_st[2*i +: 2]);
         end
      end
      check({tag, "_ok"}, ok_count, exp_ok);
      check({tag, "_err"}, err_count, exp_err);
      check({tag, "_greads"}, grid_q.size(), exp_greads);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_idle_busy"}, busy, 1'b0);
   endtask

   initial begin
      bit            ab;
      logic          dn;
      logic [DW-1:0] a_gaddr [4];
      a_gaddr = '{32'd0, 32'd1, 32'd15, 32'd9};

      load_a();
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", outs(), '0);
`ifdef PLACEMENT_READER_BBOX_EN
      check("reset_bbox", {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, {32'd3, 32'd0, 32'd3, 32'd0});
`else
      check("reset_bbox", {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, '0);
`endif
      reset = 1'b1;
      @(negedge clk);

      // All placed and consistent, o_ready held high.
      run_scan(0, 1'b1, -1, 0, ab);
      verify("a", 8'h00, 4, 0, 4);
      for (int i = 0; i < 4; i++)
         if (i < grid_q.size()) check($sformatf("a_gaddr%0d", i), grid_q[i], a_gaddr[i]);
      for (int i = 0; i < 3; i++)
         if (i + 1 < hs_q.size()) check($sformatf("a_spacing%0d", i), hs_q[i+1] - hs_q[i], 7);
`ifdef PLACEMENT_READER_BBOX_EN
      check("a_bbox", {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, {32'd0, 32'd3, 32'd0, 32'd3});
`else
      check("a_bbox", {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, '0);
`endif

      // Node 2 unplaced: no grid read for it.
      pos_x[2] = '1; pos_y[2] = '1;
      run_scan(0, 1'b1, -1, 0, ab);
      verify("b", 8'h10, 3, 1, 3);

      // Nodes 1 and 3 out of range on x and on y.
      load_a();
      pos_x[1] = 4; pos_y[1] = 0;
      pos_x[3] = 0; pos_y[3] = -2;
      run_scan(0, 1'b1, -1, 0, ab);
      verify("c", 8'h88, 2, 2, 2);

      // Grid cell (3,3) claims node 0 while node 2 sits there.
      load_a();
      grid[15] = 0;
      run_scan(0, 1'b1, -1, 0, ab);
      verify("d", 8'h30, 3, 1, 4);

      // Consumer stalls node 1 for five cycles.
      load_a();
      run_scan(5, 1'b0, -1, 0, ab);
      verify("stall", 8'h00, 4, 0, 4);

      // Reset during the second grid wait, then a clean rescan with a stray start.
      o_ready = 1'b1;
      run_scan(0, 1'b1, -1, 2, ab);
      check("abort_reached", ab, 1'b1);
      #1;
      check("abort_outputs", outs(), '0);
      @(negedge clk);
      reset = 1'b1;
      dn = 1'b0;
      repeat (4) begin
         @(negedge clk);
         dn = dn | done;
      end
      check("abort_no_done", {dn, busy}, 2'b00);
      run_scan(0, 1'b1, 10, 0, ab);
      verify("restart", 8'h00, 4, 0, 4);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
